// File: rtl/la_mailbox_pkg.sv
// rtl/la_mailbox_pkg.sv - shared types and LA bit positions for la_mailbox
//
// Purpose: opcode, status and FSM state enums plus the bit positions of the
// command/response fields carried on the 64-bit logic-analyzer bus.
// Ports: none (package).

package la_mailbox_pkg;

   // Command word layout on la_data_in
   localparam int DATA_LSB = 0;
   localparam int OP_LSB   = 32;
   localparam int ADDR_LSB = 36;
   localparam int REQ_BIT  = 40;

   // Response word layout on la_data_out
   localparam int STAT_LSB = 32;
   localparam int ACK_BIT  = 40;

   typedef enum logic [3:0] {
      OP_NOP       = 4'd0,
      OP_WR        = 4'd1,
      OP_RD        = 4'd2,
      OP_CHK       = 4'd3,
      OP_CNT_START = 4'd4,
      OP_CNT_STOP  = 4'd5,
      OP_SUM       = 4'd6
   } opcode_e;

   typedef enum logic [3:0] {
      ST_OK       = 4'd0,
      ST_ERR_OP   = 4'd1,
      ST_ERR_ADDR = 4'd2
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_SUM  = 2'd2,
      S_RESP = 2'd3
   } state_e;

endpackage

// File: rtl/la_mailbox_regfile.sv
// rtl/la_mailbox_regfile.sv - NREG x 32 mailbox register file
//
// Purpose: mailbox registers with one synchronous write port and one
// combinational read port; all registers clear on reset.
// Ports:
//   wb_clk_i  clock
//   rst_n     asynchronous active-low reset
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write data
//   raddr_i   read address
//   rdata_o   read data (combinational)

module la_mailbox_regfile #(
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic          wb_clk_i,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] regs_q [NREG];

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/la_mailbox.sv
// rtl/la_mailbox.sv - LA-bus command responder for management firmware
//
// Purpose: detects a toggled request bit on the LA bus, executes the command
// (register read/write, checkbit drive, cycle counter, register sum) and
// returns data, status and a toggled acknowledge.
// Ports:
//   wb_clk_i     clock
//   rst_n        asynchronous active-low reset
//   la_data_in   command: [31:0] data, [35:32] opcode, [39:36] addr, [40] req
//   la_oenb      LA direction; 0 = management drives the bit
//   la_data_out  response: [31:0] data, [35:32] status, [40] ack
//   io_out       checkbits on [CHK_LSB+15:CHK_LSB], zero elsewhere
//   io_oeb       low on the checkbit field once enabled, high elsewhere

module la_mailbox
   import la_mailbox_pkg::*;
#(
   parameter int NREG    = 8,
   parameter int CHK_LSB = 16
) (
   input  logic        wb_clk_i,
   input  logic        rst_n,
   input  logic [63:0] la_data_in,
   input  logic [63:0] la_oenb,
   output logic [63:0] la_data_out,
   output logic [37:0] io_out,
   output logic [37:0] io_oeb
);

   localparam int            AW       = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [4:0]    NREG_V   = 5'(NREG);
   localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);

   state_e        state_q, state_d;
   logic          req_seen_q, req_seen_d;
   logic [31:0]   data_q, data_d;
   logic [3:0]    op_q, op_d;
   logic [3:0]    addr_q, addr_d;
   logic [31:0]   resp_q, resp_d;
   status_e       status_q, status_d;
   logic [31:0]   out_resp_q, out_resp_d;
   status_e       out_status_q, out_status_d;
   logic          ack_q, ack_d;
   logic [31:0]   cnt_q, cnt_d;
   logic          cnt_run_q, cnt_run_d;
   logic [31:0]   acc_q, acc_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [15:0]   chk_q, chk_d;
   logic          chk_en_q, chk_en_d;

   logic          req_pending;
   logic          addr_ok;
   logic          rf_we;
   logic [AW-1:0] rf_raddr;
   logic [31:0]   rf_rdata;
   logic          unused_la;

   assign unused_la = ^{la_data_in[63:41], la_oenb[63:41]};

   // Any bit of the command field not driven by management blocks detection.
   assign req_pending = (la_data_in[REQ_BIT] != req_seen_q) && (la_oenb[40:0] == 41'b0);
   assign addr_ok     = ({1'b0, addr_q} < NREG_V);

   // The single read port walks idx during SUM and follows addr otherwise.
   assign rf_raddr = (state_q == S_SUM) ? idx_q : addr_q[AW-1:0];

   la_mailbox_regfile #(
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .wb_clk_i (wb_clk_i),
      .rst_n    (rst_n),
      .we_i     (rf_we),
      .waddr_i  (addr_q[AW-1:0]),
      .wdata_i  (data_q),
      .raddr_i  (rf_raddr),
      .rdata_o  (rf_rdata)
   );

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         req_seen_q   <= 1'b0;
         data_q       <= '0;
         op_q         <= '0;
         addr_q       <= '0;
         resp_q       <= '0;
         status_q     <= ST_OK;
         out_resp_q   <= '0;
         out_status_q <= ST_OK;
         ack_q        <= 1'b0;
         cnt_q        <= '0;
         cnt_run_q    <= 1'b0;
         acc_q        <= '0;
         idx_q        <= '0;
         chk_q        <= '0;
         chk_en_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_seen_q   <= req_seen_d;
         data_q       <= data_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         resp_q       <= resp_d;
         status_q     <= status_d;
         out_resp_q   <= out_resp_d;
         out_status_q <= out_status_d;
         ack_q        <= ack_d;
         cnt_q        <= cnt_d;
         cnt_run_q    <= cnt_run_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         chk_q        <= chk_d;
         chk_en_q     <= chk_en_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_seen_d   = req_seen_q;
      data_d       = data_q;
      op_d         = op_q;
      addr_d       = addr_q;
      resp_d       = resp_q;
      status_d     = status_q;
      out_resp_d   = out_resp_q;
      out_status_d = out_status_q;
      ack_d        = ack_q;
      // The counter also advances on the CNT_STOP edge, so a stop k edges
      // after the start reports k.
      cnt_d        = cnt_run_q ? cnt_q + 32'd1 : cnt_q;
      cnt_run_d    = cnt_run_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      chk_d        = chk_q;
      chk_en_d     = chk_en_q;
      rf_we        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_pending) begin
               data_d     = la_data_in[DATA_LSB +: 32];
               op_d       = la_data_in[OP_LSB +: 4];
               addr_d     = la_data_in[ADDR_LSB +: 4];
               req_seen_d = la_data_in[REQ_BIT];
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            status_d = ST_OK;
            state_d  = S_RESP;
            case (op_q)
               OP_NOP: begin
               end
               OP_WR: begin
                  if (addr_ok) rf_we = 1'b1;
                  else         status_d = ST_ERR_ADDR;
               end
               OP_RD: begin
                  if (addr_ok) resp_d = rf_rdata;
                  else         status_d = ST_ERR_ADDR;
               end
               OP_CHK: begin
                  chk_d    = data_q[15:0];
                  chk_en_d = 1'b1;
               end
               OP_CNT_START: begin
                  cnt_d     = '0;
                  cnt_run_d = 1'b1;
               end
               OP_CNT_STOP: begin
                  cnt_run_d = 1'b0;
                  resp_d    = cnt_d;
               end
               OP_SUM: begin
                  acc_d   = '0;
                  idx_d   = '0;
                  state_d = S_SUM;
               end
               default: status_d = ST_ERR_OP;
            endcase
         end
         S_SUM: begin
            acc_d = acc_q + rf_rdata;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               resp_d  = acc_d;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            out_resp_d   = resp_q;
            out_status_d = status_q;
            ack_d        = ~ack_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      la_data_out                    = '0;
      la_data_out[DATA_LSB +: 32]    = out_resp_q;
      la_data_out[STAT_LSB +: 4]     = out_status_q;
      la_data_out[ACK_BIT]           = ack_q;
      io_out                         = '0;
      io_out[CHK_LSB +: 16]          = chk_q;
      io_oeb                         = '1;
      io_oeb[CHK_LSB +: 16]          = {16{~chk_en_q}};
   end

endmodule

// File: tb/tb_la_mailbox.sv
// tb/tb_la_mailbox.sv - directed self-checking bench for la_mailbox

module tb_la_mailbox;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] la_in;
   logic [63:0] la_oenb;
   logic [63:0] dout;
   logic [37:0] io_out;
   logic [37:0] io_oeb;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic req      = 1'b0;
   int   lat;
   int   c0;
   int   c1;
   logic old_ack;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   la_mailbox #(
      .NREG    (8),
      .CHK_LSB (16)
   ) dut (
      .wb_clk_i    (clk),
      .rst_n       (rst_n),
      .la_data_in  (la_in),
      .la_oenb     (la_oenb),
      .la_data_out (dout),
      .io_out      (io_out),
      .io_oeb      (io_oeb)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] addr, input logic [31:0] data);
      req   = ~req;
      la_in = {23'b0, req, addr, op, data};
   endtask

   // lat = edges after the capture edge until ack flips; -1 if it never does
   task automatic wait_ack(input logic old, input int budget, output int l);
      l = -1;
      for (int n = 1; n <= budget; n++) begin
         @(posedge clk);
         #1;
         if (dout[40] !== old) begin
            l = n - 1;
            break;
         end
      end
   endtask

   task automatic cmd(input logic [3:0] op, input logic [3:0] addr, input logic [31:0] data,
                      output int l);
      logic old;
      old = dout[40];
      drive(op, addr, data);
      wait_ack(old, 30, l);
   endtask

   initial begin
      rst_n   = 1'b0;
      la_in   = '0;
      la_oenb = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("reset_dout", dout, 64'h0);
      check("reset_io_oeb", {26'b0, io_oeb}, 64'h3F_FFFF_FFFF);
      check("reset_io_out", {26'b0, io_out}, 64'h0);

      // write then read back
      cmd(4'd1, 4'd3, 32'hDEAD_BEEF, lat);
      check("wr_lat", 64'(lat), 64'd2);
      check("wr_ack", {63'b0, dout[40]}, 64'd1);
      check("wr_status", {60'b0, dout[35:32]}, 64'd0);
      check("wr_resp", {32'b0, dout[31:0]}, 64'd0);
      cmd(4'd2, 4'd3, 32'h0, lat);
      check("rd_lat", 64'(lat), 64'd2);
      check("rd_ack", {63'b0, dout[40]}, 64'd0);
      check("rd_resp", {32'b0, dout[31:0]}, 64'hDEAD_BEEF);
      check("rd_status", {60'b0, dout[35:32]}, 64'd0);

      // checkbits
      cmd(4'd3, 4'd0, 32'h0000_AB60, lat);
      check("chk0_io_out", {26'b0, io_out}, 64'hAB60_0000);
      check("chk0_io_oeb", {26'b0, io_oeb}, 64'h3F_0000_FFFF);
      old_ack = dout[40];
      drive(4'd3, 4'd0, 32'h0000_AB61);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("chk1_early_io_out", {26'b0, io_out}, 64'hAB61_0000);
      check("chk1_early_no_ack", {63'b0, dout[40]}, {63'b0, old_ack});
      wait_ack(old_ack, 10, lat);
      check("chk1_rest_lat", 64'(lat), 64'd0);
      check("chk1_io_oeb", {26'b0, io_oeb}, 64'h3F_0000_FFFF);

      // serial sum of 1..8
      for (int i = 0; i < 8; i++) begin
         cmd(4'd1, 4'(i), 32'(i + 1), lat);
      end
      cmd(4'd6, 4'd0, 32'h0, lat);
      check("sum_lat", 64'(lat), 64'd10);
      check("sum_resp", {32'b0, dout[31:0]}, 64'd36);
      check("sum_status", {60'b0, dout[35:32]}, 64'd0);

      // sum wraps mod 2^32
      cmd(4'd1, 4'd0, 32'hFFFF_FFFF, lat);
      cmd(4'd1, 4'd1, 32'd2, lat);
      for (int i = 2; i < 8; i++) begin
         cmd(4'd1, 4'(i), 32'd0, lat);
      end
      cmd(4'd6, 4'd0, 32'h0, lat);
      check("sumwrap_resp", {32'b0, dout[31:0]}, 64'd1);

      // address and opcode errors
      cmd(4'd2, 4'd9, 32'h0, lat);
      check("rd9_status", {60'b0, dout[35:32]}, 64'd2);
      check("rd9_resp", {32'b0, dout[31:0]}, 64'd1);
      cmd(4'd12, 4'd0, 32'h1234_5678, lat);
      check("op12_status", {60'b0, dout[35:32]}, 64'd1);
      check("op12_resp", {32'b0, dout[31:0]}, 64'd1);
      cmd(4'd1, 4'd9, 32'h5555_5555, lat);
      check("wr9_status", {60'b0, dout[35:32]}, 64'd2);
      cmd(4'd2, 4'd1, 32'h0, lat);
      check("wr9_no_alias", {32'b0, dout[31:0]}, 64'd2);
      check("rd1_status", {60'b0, dout[35:32]}, 64'd0);

      // request blocked while management does not drive bit 40
      la_oenb = 64'h0000_0100_0000_0000;
      old_ack = dout[40];
      drive(4'd0, 4'd0, 32'h0);
      wait_ack(old_ack, 50, lat);
      check("oenb_no_ack", {63'b0, lat == -1}, 64'd1);
      la_oenb = '0;
      wait_ack(old_ack, 10, lat);
      check("oenb_release_lat", 64'(lat), 64'd2);
      check("oenb_release_resp", {32'b0, dout[31:0]}, 64'd2);

      // cycle counter
      c0 = cyc;
      cmd(4'd4, 4'd0, 32'h0, lat);
      repeat (100) @(posedge clk);
      #1;
      c1 = cyc;
      cmd(4'd5, 4'd0, 32'h0, lat);
      check("cnt_resp", {32'b0, dout[31:0]}, 64'(c1 - c0));
      check("cnt_resp_abs", {32'b0, dout[31:0]}, 64'd103);
      check("cnt_status", {60'b0, dout[35:32]}, 64'd0);

      // reset during SUM with the request bit left at 1
      if (req == 1'b1) cmd(4'd0, 4'd0, 32'h0, lat);
      drive(4'd6, 4'd0, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_dout", dout, 64'h0);
      check("midrst_io_out", {26'b0, io_out}, 64'h0);
      check("midrst_io_oeb", {26'b0, io_oeb}, 64'h3F_FFFF_FFFF);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_ack(1'b0, 30, lat);
      check("postrst_lat", 64'(lat), 64'd10);
      check("postrst_ack", {63'b0, dout[40]}, 64'd1);
      check("postrst_resp", {32'b0, dout[31:0]}, 64'd0);
      cmd(4'd2, 4'd0, 32'h0, lat);
      check("postrst_reg0", {32'b0, dout[31:0]}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/la_mailbox.md
# la_mailbox

User-project block that serves as the user-side responder to management-firmware commands sent over the logic analyzer (LA) bus. Firmware writes a command word onto `la_data_in` and toggles a request bit. The block executes the command and returns data, status and a toggled acknowledge on `la_data_out`. Commands cover register read/write, a cycle counter for timing measurement, a serial register sum, and driving the 16-bit checkbit field on `mprj_io[31:16]` that the directed testbenches monitor.

## Interface
Parameters:
- `NREG`, 8: number of 32-bit mailbox registers (power of two, 2..16).
- `CHK_LSB`, 16: lowest `mprj_io` bit of the 16-bit checkbit field.

Ports. One clock; reset is asynchronous and active-low.
- `wb_clk_i`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `la_data_in`  in  64  command word: [31:0] data, [35:32] opcode, [39:36] addr, [40] req toggle, [63:41] ignored.
- `la_oenb`  in  64  LA direction; bit=0 means management drives that bit.
- `la_data_out`  out  64  response: [31:0] resp data, [35:32] status, [40] ack toggle, [39:36] and [63:41] driven 0.
- `io_out`  out  38  checkbits on [CHK_LSB+15:CHK_LSB]; all other bits 0.
- `io_oeb`  out  38  0 on the checkbit field once enabled; 1 on every other bit.

## Operation
- Request detect: internal `req_seen` holds the last serviced value of `la_data_in[40]`.
  - A request is pending when `la_data_in[40] != req_seen` and `la_oenb[40:0] == 0`.
  - If any of `la_oenb[40:0]` is 1, the block never detects a request.
- FSM states: IDLE, EXEC, SUM, RESP.
- IDLE: on a pending request, capture data, opcode and addr; set `req_seen`; go to EXEC.
- EXEC executes the opcode:
  - 0 NOP: resp unchanged, status OK.
  - 1 WR: `reg[addr] <= data`.
  - 2 RD: `resp <= reg[addr]`.
  - 3 CHK: drive `data[15:0]` on the checkbit field; set `chk_en` so `io_oeb` on that field goes 0. `chk_en` is sticky until reset.
  - 4 CNT_START: clear the counter and set it running.
  - 5 CNT_STOP: stop the counter; `resp <= count`.
  - 6 SUM: clear the accumulator and index; go to SUM.
  - 7..15: status ERR_OP; no side effects.
- Address check: for WR and RD, `addr >= NREG` gives status ERR_ADDR with no write; resp is unchanged.
- SUM: add `reg[idx]` each cycle. After `idx == NREG-1`, set `resp <= acc` (32-bit, wraps mod 2^32) and go to RESP.
- RESP: update status, toggle ack (`la_data_out[40]`), return to IDLE.
- Status codes: 0 OK, 1 ERR_OP, 2 ERR_ADDR.
- Counter: 32 bits, +1 per cycle while running, wraps to 0. CNT_START while already running restarts it from 0.
- Busy behaviour: the request bit is not sampled outside IDLE. A toggle that arrives during a command is serviced on return to IDLE.
- Firmware rule: wait for ack before toggling again. Two toggles before service cancel each other; this is intended.

## Timing
- Reset values:
  - `la_data_out` = 0 (ack = 0); `io_out` = 0; `io_oeb` = all 1.
  - `req_seen` = 0; registers = 0; counter = 0 and stopped; `chk_en` = 0; FSM in IDLE.
- Latency:
  - Single-cycle ops: toggle visible at edge t, capture at t, EXEC at t+1, ack toggles at t+2.
  - SUM: ack toggles at t+2+NREG.
- `la_data_out[31:0]` and status become valid in the same cycle that ack toggles and are held until the next ack.
- CHK: the checkbits update on the edge that ends EXEC, one cycle before ack.
- Counter: CNT_START at EXEC edge e gives count 0 at e; a CNT_STOP whose EXEC edge is k cycles later returns k.
- Reset mid-operation: all state returns to reset values immediately. A toggle still pending (`la_data_in[40] = 1`) is serviced after reset release.

## Structure
- `la_mailbox_pkg` holds:
  - opcode enum, status enum, FSM state enum;
  - LA bit-position constants (DATA_LSB, OP_LSB, ADDR_LSB, REQ_BIT, STAT_LSB, ACK_BIT).
- Sub-module `la_mailbox_regfile`: NREG×32 registers with one write port and one combinational read port. A single read port serves both RD and the serial SUM index.
- Top level contains the FSM, counter, accumulator, checkbit driver and LA output register.

## Test plan
- Reset, then wait 10 cycles: `la_data_out == 0`, `io_oeb == 38'h3F_FFFF_FFFF`, `io_out == 0`.
- WR addr 3 data 0xDEADBEEF, then RD addr 3: resp 0xDEADBEEF, status 0. The ack toggles 0→1→0, each 2 cycles after its request toggle.
- CHK data 0xAB60, then CHK 0xAB61: `io_out[31:16]` shows 0xAB60 then 0xAB61, and `io_oeb[31:16] == 0`.
- WR regs 0..7 with values 1..8, then SUM: resp 36; ack arrives 10 cycles after the toggle. Also set reg0 = 0xFFFFFFFF and reg1 = 2 (others 0): resp wraps to 1.
- RD addr 9 (NREG = 8): status 2. Opcode 12: status 1, resp unchanged. With `la_oenb[40] = 1` and the toggle flipped: no ack within 50 cycles.
- CNT_START, wait 100 cycles, CNT_STOP: resp equals the EXEC-to-EXEC cycle distance. Assert `rst_n` during a SUM: outputs return to reset values, and the pending toggle is re-serviced after release.
